// File: rtl/cla_adder_pipe_if.sv
// cla_adder_pipe_if: operand/result valid-ready bundle for the pipelined CLA adder
interface cla_adder_pipe_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] ain, bin, sum;
  modport master(output in_valid, ain, bin, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave(input in_valid, ain, bin, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: WIDTH-bit add/sub, one 8-bit carry-lookahead segment resolved per pipeline stage
module cla_adder_pipe #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  cla_adder_pipe_if.slave bus
);
  localparam int NSEG = WIDTH / 8;
  logic [WIDTH-1:0] a_q [NSEG], a_d [NSEG], b_q [NSEG], b_d [NSEG], s_q [NSEG], s_d [NSEG];
  logic [WIDTH-1:0] pa [NSEG], pb [NSEG], ps [NSEG];
  logic [NSEG-1:0] vld_q, vld_d, c_q, c_d, v_q, v_d, pc, pv;
  logic [9:0] r;
  logic advance;
  // returns {carry out, carry into bit 7, sum}; the recurrence flattens into lookahead terms
  function automatic logic [9:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [7:0] p, g;
    logic [8:0] c;
    p = a ^ b;
    g = a & b;
    c[0] = ci;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[8], c[7], p ^ c[7:0]};
  endfunction
  always_comb begin
    r = '0;
    advance = !vld_q[NSEG-1] | bus.out_ready;
    pa[0] = bus.ain;
    pb[0] = bus.sub ? ~bus.bin : bus.bin;
    pc[0] = bus.sub | bus.cin;
    ps[0] = '0;
    pv[0] = bus.in_valid;
    for (int k = 1; k < NSEG; k++) begin
      pa[k] = a_q[k-1];
      pb[k] = b_q[k-1];
      pc[k] = c_q[k-1];
      ps[k] = s_q[k-1];
      pv[k] = vld_q[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      r = cla8(pa[k][8*k +: 8], pb[k][8*k +: 8], pc[k]);
      a_d[k] = pa[k];
      b_d[k] = pb[k];
      s_d[k] = ps[k];
      s_d[k][8*k +: 8] = r[7:0];
      c_d[k] = r[9];
      v_d[k] = r[9] ^ r[8];
      vld_d[k] = pv[k];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      c_q <= '0;
      v_q <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      c_q <= c_d;
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  assign bus.in_ready = advance;
  assign bus.out_valid = vld_q[NSEG-1];
  assign bus.sum = s_q[NSEG-1];
  assign bus.cout = c_q[NSEG-1];
  assign bus.ovf = v_q[NSEG-1];
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed vectors and stall/reset sequences at WIDTH=32, random scoreboards at 8 and 64
module tb_cla_adder_pipe;
  logic clk = 0, rst = 0, rst_r = 0;
  always #5 clk = ~clk;
  int total = 0, bad = 0, rnd_done = 0, cyc = 0;
  typedef struct {logic [31:0] s; logic c, v; int t; bit lat;} exp_t;
  typedef struct {logic [31:0] a, b; logic cin, sub; logic [31:0] s; logic c, v;} vec_t;
  exp_t sb[$];
  bit stalled = 0;
  logic [33:0] held;
  cla_adder_pipe_if #(32) bus();
  cla_adder_pipe #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sbt);
    logic [64:0] m, be, f;
    m = (65'd1 << w) - 65'd1;
    be = (sbt ? ~{1'b0, b} : {1'b0, b}) & m;
    f = ({1'b0, a} & m) + be + 65'(sbt | ci);
    return {a[w-1] == be[w-1] && f[w-1] != a[w-1], f[w], f[63:0] & m[63:0]};
  endfunction
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sbt,
                       input logic ordy, input logic [33:0] e, input bit lat, output bit acc);
    exp_t x;
    @(negedge clk);
    cyc++;
    bus.in_valid = iv; bus.ain = a; bus.bin = b; bus.cin = ci; bus.sub = sbt; bus.out_ready = ordy;
    #1;
    if (bus.out_valid && !ordy) begin
      chk("stall_in_ready", bus.in_ready, 0);
      if (stalled) chk("stall_hold", {bus.ovf, bus.cout, bus.sum}, held);
      stalled = 1;
      held = {bus.ovf, bus.cout, bus.sum};
    end else begin
      chk("in_ready", bus.in_ready, 1);
      stalled = 0;
    end
    if (bus.out_valid && ordy) begin
      if (sb.size() == 0) chk("unexpected_out", bus.out_valid, 0);
      else begin
        x = sb.pop_front();
        chk("sum", bus.sum, x.s);
        chk("cout", bus.cout, x.c);
        chk("ovf", bus.ovf, x.v);
        if (x.lat) chk("latency", cyc - x.t, 4);
      end
    end
    acc = iv && bus.in_ready;
    if (acc) sb.push_back('{e[31:0], e[32], e[33], cyc, lat});
  endtask
  initial begin
    vec_t tbl[8];
    logic [31:0] sa[6], sbb[6];
    logic ss[6];
    logic [65:0] m;
    bit acc;
    int n;
    bus.in_valid = 0; bus.ain = 0; bus.bin = 0; bus.cin = 0; bus.sub = 0; bus.out_ready = 1;
    tbl = '{'{32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0},
            '{32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 1},
            '{32'h7FFFFFFF, 32'h0, 1, 0, 32'h80000000, 0, 1},
            '{32'h5, 32'h7, 0, 1, 32'hFFFFFFFE, 0, 0},
            '{32'h7, 32'h5, 0, 1, 32'h2, 1, 0},
            '{32'h80000000, 32'h1, 0, 1, 32'h7FFFFFFF, 1, 1},
            '{32'h12345678, 32'h9ABCDEF0, 1, 0, 32'hACF13569, 0, 0},
            '{32'h9, 32'h4, 1, 1, 32'h5, 1, 0}};
    #2 rst = 1; rst_r = 1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    repeat (2) @(negedge clk);
    rst = 0; rst_r = 0;
    for (int i = 0; i < 8; i++)
      cycle(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1, {tbl[i].v, tbl[i].c, tbl[i].s}, 1, acc);
    repeat (6) cycle(0, 0, 0, 0, 0, 1, 0, 0, acc);
    chk("table_drained", sb.size(), 0);
    // six offered back-to-back; consumer stalls over cycles 2..6 of the sequence
    for (int i = 0; i < 6; i++) begin
      sa[i] = $urandom; sbb[i] = $urandom; ss[i] = 1'($urandom);
    end
    n = 0;
    for (int c = 0; c < 40 && (n < 6 || sb.size() > 0); c++) begin
      m = model(32, {32'h0, sa[n % 6]}, {32'h0, sbb[n % 6]}, 0, ss[n % 6]);
      cycle(n < 6, sa[n % 6], sbb[n % 6], 0, ss[n % 6], !(c >= 2 && c < 7), {m[65], m[64], m[31:0]}, 0, acc);
      if (acc) n++;
    end
    chk("stall_sent", n, 6);
    chk("stall_drained", sb.size(), 0);
    // three in flight, first one parked at the output, then reset
    for (int i = 0; i < 3; i++) cycle(1, 32'h100 + i, 32'h3, 0, 0, 0, 0, 0, acc);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    #2 rst = 1;
    #1 chk("rst_mid_out_valid", bus.out_valid, 0);
    sb.delete();
    stalled = 0;
    bus.in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (8) cycle(0, 0, 0, 0, 0, 1, 0, 0, acc);
    cycle(1, 32'hDEADBEEF, 32'h21524111, 0, 0, 1, {1'b0, 1'b1, 32'h00000000}, 1, acc);
    repeat (6) cycle(0, 0, 0, 0, 0, 1, 0, 0, acc);
    chk("post_rst_drained", sb.size(), 0);
    for (int i = 0; i < 30000 && rnd_done < 2; i++) @(negedge clk);
    chk("rnd_finished", rnd_done, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  for (genvar g = 0; g < 2; g++) begin : rnd
    localparam int W = g ? 64 : 8;
    localparam int N = W / 8;
    cla_adder_pipe_if #(W) rb();
    cla_adder_pipe #(.WIDTH(W)) u(.clk(clk), .rst(rst_r), .bus(rb));
    initial begin
      logic [W+1:0] eq[$];
      int tq[$];
      bit lq[$];
      int sent, c, latn;
      bit pend, lat;
      logic [63:0] a, b;
      logic ci, sbt;
      logic [65:0] m;
      sent = 0; c = 0; latn = 0; pend = 0; a = 0; b = 0; ci = 0; sbt = 0;
      rb.in_valid = 0; rb.ain = 0; rb.bin = 0; rb.cin = 0; rb.sub = 0; rb.out_ready = 1;
      @(negedge rst_r);
      while ((sent < 1000 || eq.size() > 0) && c < 20000) begin
        @(negedge clk);
        c++;
        if (!pend) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom};
          ci = 1'($urandom); sbt = 1'($urandom);
          pend = sent < 1000 && $urandom_range(3) != 0;
        end
        rb.in_valid = pend; rb.ain = a[W-1:0]; rb.bin = b[W-1:0]; rb.cin = ci; rb.sub = sbt;
        rb.out_ready = (sent < 500 || latn > 0) ? 1'b1 : 1'($urandom_range(3) != 0);
        #1;
        if (rb.out_valid && rb.out_ready) begin
          if (eq.size() == 0) chk($sformatf("rnd%0d_unexpected", W), rb.out_valid, 0);
          else begin
            chk($sformatf("rnd%0d_result", W), {rb.ovf, rb.cout, rb.sum}, eq.pop_front());
            lat = lq.pop_front();
            if (lat) begin
              chk($sformatf("rnd%0d_latency", W), c - tq[0], N);
              latn--;
            end
            void'(tq.pop_front());
          end
        end
        if (rb.in_valid && rb.in_ready) begin
          m = model(W, a, b, ci, sbt);
          eq.push_back({m[65], m[64], m[W-1:0]});
          tq.push_back(c);
          lq.push_back(sent < 500);
          if (sent < 500) latn++;
          pend = 0;
          sent++;
        end
      end
      rb.in_valid = 0;
      chk($sformatf("rnd%0d_drained", W), eq.size(), 0);
      chk($sformatf("rnd%0d_sent", W), sent, 1000);
      rnd_done++;
    end
  end
endmodule
